instr_align: RTL and testbench
==============================

# instr_align

Fetch-to-decode alignment stage for the RV32IC pipeline. Sits between instruction fetch and decode and acts as the IF/ID pipeline register. It takes 32-bit fetched words with their PC and splits them into 16-bit compressed and 32-bit instructions, including 32-bit instructions that span two words. Compressed instructions are expanded to their RV32I equivalents, so decode only ever sees 32-bit encodings. It drives the fetch stall when a word still holds an unissued halfword.

## Interface
- RESET_PC, 32'h100, reset value of id_pc
- clk  in  1  clock
- reset  in  1  reset (already decided): synchronous, active-high
- fetch_valid  in  1  fetch_word/fetch_pc are valid this cycle
- fetch_pc  in  32  PC of fetch_word; bit 1 set only after a jump to a halfword target
- fetch_word  in  32  fetched word, little-endian halfwords
- jmp  in  1  redirect/flush from execute
- dec_stall  in  1  decode cannot accept a new instruction
- fetch_stall  out  1  fetch must re-present the same word next cycle
- id_valid  out  1  id_* holds a real instruction
- id_pc  out  32  PC of the issued instruction
- id_instr  out  32  expanded/aligned instruction
- id_compressed  out  1  source instruction was 16-bit
- id_illegal  out  1  compressed encoding has no RV32 expansion

## Operation
- Halfword buffer: buf_hw[15:0], buf_pc[31:0]. State machine:
  - EMPTY: no leftover halfword.
  - HALF: buffer holds the low half of a 32-bit instruction.
  - PEND: buffer holds a compressed halfword awaiting issue.
- A halfword is compressed iff bits[1:0] != 2'b11.
- EMPTY, fetch_valid, fetch_pc[1]=0, low half (lo):
  - lo is 32-bit: issue fetch_word at fetch_pc; stay EMPTY.
  - lo is compressed: issue expand(lo) at fetch_pc. Then handle the high half (hi) at fetch_pc+2:
    - hi compressed: buffer it, go PEND.
    - hi 32-bit: buffer it, go HALF.
- EMPTY, fetch_valid, fetch_pc[1]=1: ignore lo and treat hi as above.
  - hi compressed: issue it now at fetch_pc; stay EMPTY.
  - hi 32-bit: buffer it, go HALF; nothing issued.
- HALF with fetch_valid:
  - Issue {lo, buf_hw} at buf_pc with id_compressed=0.
  - Then handle hi as in EMPTY: PEND if compressed, HALF if 32-bit.
- PEND:
  - Issue expand(buf_hw) at buf_pc; go EMPTY.
  - The input word is not consumed; fetch_stall=1.
- fetch_valid=0 outside PEND: nothing issued; state and buffer hold.
- fetch_stall = dec_stall | (state==PEND), combinational.
- dec_stall=1: id_*, state and buffer all hold.
- jmp (highest priority, overrides dec_stall): state goes to EMPTY, buffer is invalidated, id_valid goes to 0 at the next edge; the same-cycle fetch word is dropped.
- Illegal compressed encodings (including 0x0000 and F/D forms): id_illegal=1, id_instr={16'h0, halfword}, id_compressed=1.
- PC arithmetic is modulo 2^32.

## Timing
- Reset values: id_valid=0, id_pc=RESET_PC, id_instr=32'h0000_0013 (NOP), id_compressed=0, id_illegal=0, state=EMPTY.
- Latency is 1 cycle: the word presented in cycle t appears on id_* after edge t+1.
- A word holding two compressed instructions issues them on consecutive cycles, with fetch_stall high during the second cycle.
- A spanning 32-bit instruction issues in the cycle after its second word is presented.
- When issuing nothing (and not stalled), id_valid=0 and the other id_* outputs hold.

## Structure
- Shared package rv_pkg:
  - RV_NOP constant
  - align_state_t enum {EMPTY, HALF, PEND}
  - RV32I opcode constants used by the expander
- Sub-module rvc_expand: purely combinational, 16-bit in, 32-bit out plus illegal flag; covers RV32C quadrants 0–2.
- The top level holds the FSM, the buffer and the output register.

## Test plan
- 0x00A50513 at 0x100 -> next cycle id_valid=1, id_pc=0x100, id_instr=0x00A50513, id_compressed=0.
- 0x45050505 at 0x104:
  - Cycle 1: id_instr=0x00150513 (c.addi), id_pc=0x104.
  - Cycle 2: fetch_stall=1; id_instr=0x00100513 (c.li), id_pc=0x106.
- Spanning: 0x05130505 at 0x108, then 0x????00A5 at 0x10C -> c.addi at 0x108, then 0x00A50513 at 0x10A.
- Jump to 0x112 with word 0x4505xxxx -> only id_instr=0x00100513 issues, id_pc=0x112.
- jmp asserted in HALF with dec_stall=1 -> id_valid=0 next cycle; the buffered half is never issued.
- Halfword 0x0000 -> id_illegal=1, id_instr=0x00000000. dec_stall held 3 cycles -> id_* stable and fetch_stall=1 throughout.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV32IC definitions for the fetch/decode front end:
// NOP encoding, alignment FSM states and RV32I major opcodes.
package rv_pkg;

    localparam logic [31:0] RV_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        PEND  = 2'd2
    } align_state_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    function automatic logic is_rvc(input logic [15:0] hw);
        return hw[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/rvc_expand.sv
// Combinational RV32C -> RV32I expander (quadrants 0-2).
// F/D forms and reserved encodings flag illegal and echo the halfword.
module rvc_expand
    import rv_pkg::*;
(
    input  logic [15:0] hw_i,
    output logic [31:0] instr_o,
    output logic        illegal_o
);

    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [4:0]  rs2;
    logic [4:0]  rdp;
    logic [4:0]  rs1p;
    logic [5:0]  imm6;
    logic [11:0] imm6_sx;
    logic [20:0] jimm;
    logic [12:0] bimm;
    logic [11:0] sp16;
    logic [9:0]  nzuimm;
    logic [6:0]  lwimm;
    logic [7:0]  lwsp;
    logic [7:0]  swsp;
    logic [31:0] res;
    logic        ill;

    assign f3      = hw_i[15:13];
    assign rd      = hw_i[11:7];
    assign rs2     = hw_i[6:2];
    assign rdp     = {2'b01, hw_i[4:2]};
    assign rs1p    = {2'b01, hw_i[9:7]};
    assign imm6    = {hw_i[12], hw_i[6:2]};
    assign imm6_sx = {{6{hw_i[12]}}, imm6};
    assign jimm    = {{9{hw_i[12]}}, hw_i[12], hw_i[8], hw_i[10:9],
                      hw_i[6], hw_i[7], hw_i[2], hw_i[11],
                      hw_i[5:3], 1'b0};
    assign bimm    = {{4{hw_i[12]}}, hw_i[12], hw_i[6:5], hw_i[2],
                      hw_i[11:10], hw_i[4:3], 1'b0};
    assign sp16    = {{2{hw_i[12]}}, hw_i[12], hw_i[4:3], hw_i[5],
                      hw_i[2], hw_i[6], 4'b0};
    assign nzuimm  = {hw_i[10:7], hw_i[12:11], hw_i[5], hw_i[6], 2'b00};
    assign lwimm   = {hw_i[5], hw_i[12:10], hw_i[6], 2'b00};
    assign lwsp    = {hw_i[3:2], hw_i[12], hw_i[6:4], 2'b00};
    assign swsp    = {hw_i[8:7], hw_i[12:9], 2'b00};

    always_comb begin
        res = RV_NOP;
        ill = 1'b0;
        case (hw_i[1:0])
            2'b00: begin
                case (f3)
                    3'b000: begin
                        ill = (nzuimm == 10'd0);
                        res = {2'b0, nzuimm, 5'd2, 3'b000, rdp, OPC_OP_IMM};
                    end
                    3'b010: res = {5'b0, lwimm, rs1p, 3'b010, rdp, OPC_LOAD};
                    3'b110: res = {5'b0, lwimm[6:5], rdp, rs1p, 3'b010,
                                   lwimm[4:0], OPC_STORE};
                    default: ill = 1'b1;
                endcase
            end
            2'b01: begin
                case (f3)
                    3'b000: res = {imm6_sx, rd, 3'b000, rd, OPC_OP_IMM};
                    3'b001: res = {jimm[20], jimm[10:1], jimm[11],
                                   jimm[19:12], 5'd1, OPC_JAL};
                    3'b010: res = {imm6_sx, 5'd0, 3'b000, rd, OPC_OP_IMM};
                    3'b011: begin
                        ill = (imm6 == 6'd0);
                        if (rd == 5'd2)
                            res = {sp16, 5'd2, 3'b000, 5'd2, OPC_OP_IMM};
                        else
                            res = {{15{hw_i[12]}}, hw_i[6:2], rd, OPC_LUI};
                    end
                    3'b100: begin
                        case (hw_i[11:10])
                            2'b00: begin
                                ill = hw_i[12];
                                res = {7'b0, hw_i[6:2], rs1p, 3'b101,
                                       rs1p, OPC_OP_IMM};
                            end
                            2'b01: begin
                                ill = hw_i[12];
                                res = {7'b0100000, hw_i[6:2], rs1p, 3'b101,
                                       rs1p, OPC_OP_IMM};
                            end
                            2'b10: res = {imm6_sx, rs1p, 3'b111, rs1p,
                                          OPC_OP_IMM};
                            default: begin
                                // bit 12 set selects the RV64-only subw/addw
                                ill = hw_i[12];
                                case (hw_i[6:5])
                                    2'b00: res = {7'b0100000, rdp, rs1p,
                                                  3'b000, rs1p, OPC_OP};
                                    2'b01: res = {7'b0, rdp, rs1p, 3'b100,
                                                  rs1p, OPC_OP};
                                    2'b10: res = {7'b0, rdp, rs1p, 3'b110,
                                                  rs1p, OPC_OP};
                                    default: res = {7'b0, rdp, rs1p, 3'b111,
                                                    rs1p, OPC_OP};
                                endcase
                            end
                        endcase
                    end
                    3'b101: res = {jimm[20], jimm[10:1], jimm[11],
                                   jimm[19:12], 5'd0, OPC_JAL};
                    3'b110: res = {bimm[12], bimm[10:5], 5'd0, rs1p, 3'b000,
                                   bimm[4:1], bimm[11], OPC_BRANCH};
                    default: res = {bimm[12], bimm[10:5], 5'd0, rs1p,
                                    3'b001, bimm[4:1], bimm[11], OPC_BRANCH};
                endcase
            end
            2'b10: begin
                case (f3)
                    3'b000: begin
                        ill = hw_i[12];
                        res = {7'b0, hw_i[6:2], rd, 3'b001, rd, OPC_OP_IMM};
                    end
                    3'b010: begin
                        ill = (rd == 5'd0);
                        res = {4'b0, lwsp, 5'd2, 3'b010, rd, OPC_LOAD};
                    end
                    3'b100: begin
                        if (!hw_i[12]) begin
                            if (rs2 == 5'd0) begin
                                ill = (rd == 5'd0);
                                res = {12'b0, rd, 3'b000, 5'd0, OPC_JALR};
                            end else begin
                                res = {7'b0, rs2, 5'd0, 3'b000, rd, OPC_OP};
                            end
                        end else if (rs2 == 5'd0) begin
                            if (rd == 5'd0)
                                res = {12'd1, 5'd0, 3'b000, 5'd0, OPC_SYSTEM};
                            else
                                res = {12'b0, rd, 3'b000, 5'd1, OPC_JALR};
                        end else begin
                            res = {7'b0, rs2, rd, 3'b000, rd, OPC_OP};
                        end
                    end
                    3'b110: res = {4'b0, swsp[7:5], rs2, 5'd2, 3'b010,
                                   swsp[4:0], OPC_STORE};
                    default: ill = 1'b1;
                endcase
            end
            default: ill = 1'b1;
        endcase
    end

    assign illegal_o = ill;
    assign instr_o   = ill ? {16'h0, hw_i} : res;

endmodule

// File: rtl/instr_align.sv
// IF/ID register: splits fetch words into 16/32-bit instructions,
// stitches word-spanning ones and expands RVC for decode.
module instr_align
    import rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_pc,
    input  logic [31:0] fetch_word,
    input  logic        jmp,
    input  logic        dec_stall,
    output logic        fetch_stall,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    output logic        id_compressed,
    output logic        id_illegal
);

    align_state_t state_q, state_d;
    logic [15:0]  buf_hw_q, buf_hw_d;
    logic [31:0]  buf_pc_q, buf_pc_d;
    logic         vld_q, vld_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic         comp_q, comp_d;
    logic         ill_q, ill_d;

    logic [15:0]  lo;
    logic [15:0]  hi;
    logic [15:0]  exp_hw;
    logic [31:0]  exp_instr;
    logic         exp_ill;
    logic         take_hi;

    assign lo = fetch_word[15:0];
    assign hi = fetch_word[31:16];

    rvc_expand u_expand (
        .hw_i      (exp_hw),
        .instr_o   (exp_instr),
        .illegal_o (exp_ill)
    );

    // Only one halfword needs expanding per cycle; pick it by state.
    always_comb begin
        exp_hw = lo;
        if (state_q == PEND)
            exp_hw = buf_hw_q;
        else if (state_q == EMPTY && fetch_pc[1])
            exp_hw = hi;
    end

    always_comb begin
        state_d  = state_q;
        buf_hw_d = buf_hw_q;
        buf_pc_d = buf_pc_q;
        vld_d    = 1'b0;
        pc_d     = pc_q;
        instr_d  = instr_q;
        comp_d   = comp_q;
        ill_d    = ill_q;
        take_hi  = 1'b0;
        if (jmp) begin
            state_d = EMPTY;
        end else if (dec_stall) begin
            vld_d = vld_q;
        end else begin
            case (state_q)
                PEND: begin
                    vld_d   = 1'b1;
                    pc_d    = buf_pc_q;
                    instr_d = exp_instr;
                    comp_d  = 1'b1;
                    ill_d   = exp_ill;
                    state_d = EMPTY;
                end
                HALF: begin
                    if (fetch_valid) begin
                        vld_d   = 1'b1;
                        pc_d    = buf_pc_q;
                        instr_d = {lo, buf_hw_q};
                        comp_d  = 1'b0;
                        ill_d   = 1'b0;
                        take_hi = 1'b1;
                    end
                end
                default: begin
                    if (fetch_valid) begin
                        if (fetch_pc[1]) begin
                            if (is_rvc(hi)) begin
                                vld_d   = 1'b1;
                                pc_d    = fetch_pc;
                                instr_d = exp_instr;
                                comp_d  = 1'b1;
                                ill_d   = exp_ill;
                            end else begin
                                buf_hw_d = hi;
                                buf_pc_d = fetch_pc;
                                state_d  = HALF;
                            end
                        end else if (!is_rvc(lo)) begin
                            vld_d   = 1'b1;
                            pc_d    = fetch_pc;
                            instr_d = fetch_word;
                            comp_d  = 1'b0;
                            ill_d   = 1'b0;
                        end else begin
                            vld_d   = 1'b1;
                            pc_d    = fetch_pc;
                            instr_d = exp_instr;
                            comp_d  = 1'b1;
                            ill_d   = exp_ill;
                            take_hi = 1'b1;
                        end
                    end
                end
            endcase
            if (take_hi) begin
                buf_hw_d = hi;
                buf_pc_d = fetch_pc + 32'd2;
                state_d  = is_rvc(hi) ? PEND : HALF;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= EMPTY;
            buf_hw_q <= 16'h0;
            buf_pc_q <= 32'h0;
            vld_q    <= 1'b0;
            pc_q     <= RESET_PC;
            instr_q  <= RV_NOP;
            comp_q   <= 1'b0;
            ill_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            buf_hw_q <= buf_hw_d;
            buf_pc_q <= buf_pc_d;
            vld_q    <= vld_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            comp_q   <= comp_d;
            ill_q    <= ill_d;
        end
    end

    assign fetch_stall   = dec_stall | (state_q == PEND);
    assign id_valid      = vld_q;
    assign id_pc         = pc_q;
    assign id_instr      = instr_q;
    assign id_compressed = comp_q;
    assign id_illegal    = ill_q;

endmodule

// File: tb/tb_instr_align.sv
// Bench for instr_align: RVC vector table, directed corner sequences,
// and a random halfword stream checked against an in-order queue.
module tb_instr_align;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_word;
    logic        jmp;
    logic        dec_stall;
    logic        fetch_stall;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic        id_compressed;
    logic        id_illegal;

    int checks = 0;
    int errors = 0;

    instr_align #(.RESET_PC(32'h100)) dut (
        .clk           (clk),
        .reset         (reset),
        .fetch_valid   (fetch_valid),
        .fetch_pc      (fetch_pc),
        .fetch_word    (fetch_word),
        .jmp           (jmp),
        .dec_stall     (dec_stall),
        .fetch_stall   (fetch_stall),
        .id_valid      (id_valid),
        .id_pc         (id_pc),
        .id_instr      (id_instr),
        .id_compressed (id_compressed),
        .id_illegal    (id_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] hw;
        logic [31:0] instr;
        logic        ill;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        comp;
        logic        ill;
    } exp_t;

    vec_t vt[21];

    function automatic logic [66:0] outs();
        return {id_valid, id_pc, id_instr, id_compressed, id_illegal};
    endfunction

    function automatic logic [66:0] mk(input logic v, input logic [31:0] pc,
                                       input logic [31:0] ins,
                                       input logic c, input logic il);
        return {v, pc, ins, c, il};
    endfunction

    task automatic chk(input string name, input logic [66:0] act,
                       input logic [66:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got v=%b pc=%h ins=%h c=%b il=%b want v=%b pc=%h ins=%h c=%b il=%b",
                     name, act[66], act[65:34], act[33:2], act[1], act[0],
                     exp[66], exp[65:34], exp[33:2], exp[1], exp[0]);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic drive(input logic fv, input logic [31:0] pc,
                         input logic [31:0] w, input logic j,
                         input logic ds);
        fetch_valid = fv;
        fetch_pc    = pc;
        fetch_word  = w;
        jmp         = j;
        dec_stall   = ds;
        #1;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    logic [15:0] hws[$];
    exp_t        expq[$];
    exp_t        e;
    logic [66:0] snap;

    initial begin
        vt[0]  = '{16'h0505, 32'h00150513, 1'b0};
        vt[1]  = '{16'h4505, 32'h00100513, 1'b0};
        vt[2]  = '{16'h0000, 32'h00000000, 1'b1};
        vt[3]  = '{16'h4108, 32'h00052503, 1'b0};
        vt[4]  = '{16'h8082, 32'h00008067, 1'b0};
        vt[5]  = '{16'h9002, 32'h00100073, 1'b0};
        vt[6]  = '{16'h852E, 32'h00B00533, 1'b0};
        vt[7]  = '{16'h2000, 32'h00002000, 1'b1};
        vt[8]  = '{16'h6000, 32'h00006000, 1'b1};
        vt[9]  = '{16'hA001, 32'h0000006F, 1'b0};
        vt[10] = '{16'h8C05, 32'h40940433, 1'b0};
        vt[11] = '{16'h6505, 32'h00001537, 1'b0};
        vt[12] = '{16'h6101, 32'h00006101, 1'b1};
        vt[13] = '{16'h0506, 32'h00151513, 1'b0};
        vt[14] = '{16'h557D, 32'hFFF00513, 1'b0};
        vt[15] = '{16'h4512, 32'h00412503, 1'b0};
        vt[16] = '{16'hC42A, 32'h00A12423, 1'b0};
        vt[17] = '{16'h0040, 32'h00410413, 1'b0};
        vt[18] = '{16'hE001, 32'h00041063, 1'b0};
        vt[19] = '{16'h8005, 32'h00145413, 1'b0};
        vt[20] = '{16'h0001, 32'h00000013, 1'b0};

        do_reset();
        chk("reset_outs", outs(), mk(1'b0, 32'h100, 32'h13, 1'b0, 1'b0));
        chk1("reset_fstall", fetch_stall, 1'b0);

        // plain 32-bit word
        drive(1'b1, 32'h100, 32'h00A50513, 1'b0, 1'b0);
        cyc();
        chk("w32", outs(), mk(1'b1, 32'h100, 32'h00A50513, 1'b0, 1'b0));

        // two compressed in one word
        drive(1'b1, 32'h104, 32'h45050505, 1'b0, 1'b0);
        cyc();
        chk("cc_first", outs(), mk(1'b1, 32'h104, 32'h00150513, 1'b1, 1'b0));
        drive(1'b1, 32'h108, 32'h05130505, 1'b0, 1'b0);
        chk1("cc_fstall", fetch_stall, 1'b1);
        cyc();
        chk("cc_second", outs(), mk(1'b1, 32'h106, 32'h00100513, 1'b1, 1'b0));

        // spanning 32-bit instruction
        chk1("span_nostall", fetch_stall, 1'b0);
        cyc();
        chk("span_c", outs(), mk(1'b1, 32'h108, 32'h00150513, 1'b1, 1'b0));
        drive(1'b1, 32'h10C, 32'h000100A5, 1'b0, 1'b0);
        cyc();
        chk("span_32", outs(), mk(1'b1, 32'h10A, 32'h00A50513, 1'b0, 1'b0));
        drive(1'b0, 32'h110, 32'h0, 1'b0, 1'b0);
        cyc();
        chk("span_nop", outs(), mk(1'b1, 32'h10E, 32'h00000013, 1'b1, 1'b0));
        cyc();
        chk("idle_hold", outs(), mk(1'b0, 32'h10E, 32'h00000013, 1'b1, 1'b0));

        // jump to a halfword target
        drive(1'b1, 32'h200, 32'h00A50513, 1'b1, 1'b0);
        cyc();
        chk1("jmp_drop", id_valid, 1'b0);
        drive(1'b1, 32'h112, 32'h4505ABCD, 1'b0, 1'b0);
        cyc();
        chk("jmp_half", outs(), mk(1'b1, 32'h112, 32'h00100513, 1'b1, 1'b0));
        drive(1'b0, 32'h116, 32'h0, 1'b0, 1'b0);
        cyc();
        chk1("jmp_half_once", id_valid, 1'b0);

        // jmp in HALF overrides dec_stall and drops the buffer
        drive(1'b1, 32'h120, 32'h05130505, 1'b0, 1'b0);
        cyc();
        chk("half_fill", outs(), mk(1'b1, 32'h120, 32'h00150513, 1'b1, 1'b0));
        drive(1'b1, 32'h124, 32'h000000A5, 1'b1, 1'b1);
        cyc();
        chk1("jmp_stall_v", id_valid, 1'b0);
        drive(1'b1, 32'h200, 32'h00A50513, 1'b0, 1'b0);
        cyc();
        chk("jmp_flushed", outs(), mk(1'b1, 32'h200, 32'h00A50513, 1'b0, 1'b0));

        // illegal 0x0000 pair, decode stalled 3 cycles
        drive(1'b1, 32'h300, 32'h00000000, 1'b0, 1'b0);
        cyc();
        chk("ill_first", outs(), mk(1'b1, 32'h300, 32'h0, 1'b1, 1'b1));
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h304, 32'h00A50513, 1'b0, 1'b1);
            chk1("dstall_fstall", fetch_stall, 1'b1);
            cyc();
            chk("dstall_hold", outs(), mk(1'b1, 32'h300, 32'h0, 1'b1, 1'b1));
        end
        drive(1'b1, 32'h304, 32'h00A50513, 1'b0, 1'b0);
        chk1("pend_fstall", fetch_stall, 1'b1);
        cyc();
        chk("ill_second", outs(), mk(1'b1, 32'h302, 32'h0, 1'b1, 1'b1));
        cyc();
        chk("after_pend", outs(), mk(1'b1, 32'h304, 32'h00A50513, 1'b0, 1'b0));

        // PC wraps modulo 2^32
        drive(1'b1, 32'hFFFFFFFC, 32'h45050505, 1'b0, 1'b0);
        cyc();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        cyc();
        chk("wrap_pc", outs(), mk(1'b1, 32'hFFFFFFFE, 32'h00100513, 1'b1, 1'b0));

        // expander table, each halfword presented at a halfword PC
        do_reset();
        for (int i = 0; i < 21; i++) begin
            drive(1'b1, 32'h400 + 32'(i) * 4 + 2, {vt[i].hw, 16'h1234},
                  1'b0, 1'b0);
            cyc();
            chk($sformatf("vec%0d_%h", i, vt[i].hw), outs(),
                mk(1'b1, 32'h400 + 32'(i) * 4 + 2, vt[i].instr, 1'b1,
                   vt[i].ill));
        end

        // random stream against an in-order expected queue
        do_reset();
        begin
            logic [31:0] base;
            logic [31:0] w32;
            int          k;
            int          widx;
            int          nw;
            int          budget;
            logic        adv;
            logic        prev_ds;
            base = 32'hFFFFFF00;
            for (int n = 0; n < 300; n++) begin
                logic [31:0] ipc;
                ipc = base + 32'(hws.size()) * 2;
                if ($urandom_range(1) == 0) begin
                    k = $urandom_range(20);
                    hws.push_back(vt[k].hw);
                    expq.push_back('{ipc, vt[k].instr, 1'b1, vt[k].ill});
                end else begin
                    w32 = $urandom | 32'h3;
                    hws.push_back(w32[15:0]);
                    hws.push_back(w32[31:16]);
                    expq.push_back('{ipc, w32, 1'b0, 1'b0});
                end
            end
            if (hws.size() % 2 == 1) begin
                expq.push_back('{base + 32'(hws.size()) * 2, 32'h13,
                                 1'b1, 1'b0});
                hws.push_back(16'h0001);
            end
            nw = hws.size() / 2;
            widx = 0;
            budget = 0;
            while (expq.size() > 0 && budget < 5000) begin
                budget++;
                if (widx < nw)
                    drive($urandom_range(3) != 0, base + 32'(widx) * 4,
                          {hws[2*widx+1], hws[2*widx]}, 1'b0,
                          $urandom_range(3) == 0);
                else
                    drive(1'b0, 32'h0, 32'h0, 1'b0,
                          $urandom_range(3) == 0);
                adv = fetch_valid && !fetch_stall;
                prev_ds = dec_stall;
                cyc();
                if (adv)
                    widx++;
                if (!prev_ds && id_valid) begin
                    snap = outs();
                    if (expq.size() == 0) begin
                        chk("rnd_extra", snap, '0);
                    end else begin
                        e = expq.pop_front();
                        chk("rnd_issue", snap,
                            mk(1'b1, e.pc, e.instr, e.comp, e.ill));
                    end
                end
            end
            chk1("rnd_drained", expq.size() == 0, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
